// File: rtl/cim_temp_mem_responder_if.sv
// Request-side bundle shared by the CiM sub-units that access temporary-result storage.
// read_req_src / write_req_src are one-hot over the request sources.
interface MemAccessSignals #(
  parameter int unsigned N_STORAGE                 = 16,
  parameter int unsigned TEMP_RES_STORAGE_SIZE_CIM = 848,
  parameter int unsigned MEM_ACCESS_SRC_NUM        = 6
);
  localparam int unsigned AW = $clog2(TEMP_RES_STORAGE_SIZE_CIM);

  logic [MEM_ACCESS_SRC_NUM-1:0] read_req_src;
  logic [MEM_ACCESS_SRC_NUM-1:0] write_req_src;
  logic [AW-1:0]                 addr_table [MEM_ACCESS_SRC_NUM];
  logic [N_STORAGE-1:0]          write_data [MEM_ACCESS_SRC_NUM];

  modport master (
    output read_req_src,
    output write_req_src,
    output addr_table,
    output write_data
  );

  modport slave (
    input read_req_src,
    input write_req_src,
    input addr_table,
    input write_data
  );
endinterface

// File: rtl/cim_temp_mem_responder.sv
// 1R1W temporary-result storage responder: lowest-index source select, 2-cycle tagged reads,
// sticky protocol error flags. Define CIM_MEM_WR_BYPASS_EN to forward same-address writes to reads.
module cim_temp_mem_responder #(
  parameter int unsigned N_STORAGE                 = 16,
  parameter int unsigned TEMP_RES_STORAGE_SIZE_CIM = 848,
  parameter int unsigned MEM_ACCESS_SRC_NUM        = 6,
  localparam int unsigned AW                       = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
  localparam int unsigned IdxW                     = $clog2(MEM_ACCESS_SRC_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  MemAccessSignals.slave                mem_if,
  input  logic                          clr_err,
  output logic [N_STORAGE-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [MEM_ACCESS_SRC_NUM-1:0] rd_dst,
  output logic                          err_multi_rd,
  output logic                          err_multi_wr,
  output logic                          err_addr_oob
);

  localparam logic [MEM_ACCESS_SRC_NUM-1:0] SrcOne = MEM_ACCESS_SRC_NUM'(1);
  localparam logic [AW:0]                   Depth  = (AW + 1)'(TEMP_RES_STORAGE_SIZE_CIM);

  logic [N_STORAGE-1:0] mem_q [TEMP_RES_STORAGE_SIZE_CIM];

  // Source selection
  logic                          rd_hit, wr_hit;
  logic [IdxW-1:0]               rd_idx, wr_idx;
  logic [MEM_ACCESS_SRC_NUM-1:0] rd_onehot;
  logic [AW-1:0]                 rd_addr, wr_addr;
  logic [N_STORAGE-1:0]          wr_data;
  logic                          rd_oob, wr_oob, multi_rd, multi_wr;
  logic                          wr_en;
  logic [N_STORAGE-1:0]          rd_word;

  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    rd_idx = '0;
    wr_idx = '0;
    // Descending scan so the lowest set index is the one left standing.
    for (int i = MEM_ACCESS_SRC_NUM - 1; i >= 0; i--) begin
      if (mem_if.read_req_src[i]) begin
        rd_hit = 1'b1;
        rd_idx = IdxW'(i);
      end
      if (mem_if.write_req_src[i]) begin
        wr_hit = 1'b1;
        wr_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    rd_onehot = rd_hit ? (SrcOne << rd_idx) : '0;
    rd_addr   = mem_if.addr_table[rd_idx];
    wr_addr   = mem_if.addr_table[wr_idx];
    wr_data   = mem_if.write_data[wr_idx];
    rd_oob    = rd_hit && ({1'b0, rd_addr} >= Depth);
    wr_oob    = wr_hit && ({1'b0, wr_addr} >= Depth);
    multi_rd  = (mem_if.read_req_src & (mem_if.read_req_src - SrcOne)) != '0;
    multi_wr  = (mem_if.write_req_src & (mem_if.write_req_src - SrcOne)) != '0;
    wr_en     = wr_hit && !wr_oob && !rst;
  end

  // Storage array: not reset, written at the end of the request cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read pipeline
  logic                          s1_valid_q, s1_valid_d;
  logic [MEM_ACCESS_SRC_NUM-1:0] s1_dst_q, s1_dst_d;
  logic [N_STORAGE-1:0]          s1_data_q, s1_data_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [MEM_ACCESS_SRC_NUM-1:0] rd_dst_q, rd_dst_d;
  logic [N_STORAGE-1:0]          rd_data_q, rd_data_d;

  always_comb begin
    rd_word = '0;
    if (rd_hit && !rd_oob) begin
      rd_word = mem_q[rd_addr];
`ifdef CIM_MEM_WR_BYPASS_EN
      if (wr_hit && !wr_oob && (wr_addr == rd_addr)) begin
        rd_word = wr_data;
      end
`endif
    end
  end

  always_comb begin
    s1_valid_d = rd_hit;
    s1_dst_d   = rd_onehot;
    s1_data_d  = rd_word;
    rd_valid_d = s1_valid_q;
    rd_dst_d   = s1_dst_q;
    rd_data_d  = s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dst_q   <= '0;
      s1_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_dst_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dst_q   <= s1_dst_d;
      s1_data_q  <= s1_data_d;
      rd_valid_q <= rd_valid_d;
      rd_dst_q   <= rd_dst_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  logic err_multi_rd_q, err_multi_rd_d;
  logic err_multi_wr_q, err_multi_wr_d;
  logic err_addr_oob_q, err_addr_oob_d;

  always_comb begin
    err_multi_rd_d = err_multi_rd_q;
    err_multi_wr_d = err_multi_wr_q;
    err_addr_oob_d = err_addr_oob_q;
    if (clr_err) begin
      err_multi_rd_d = 1'b0;
      err_multi_wr_d = 1'b0;
      err_addr_oob_d = 1'b0;
    end
    if (multi_rd) begin
      err_multi_rd_d = 1'b1;
    end
    if (multi_wr) begin
      err_multi_wr_d = 1'b1;
    end
    if (rd_oob || wr_oob) begin
      err_addr_oob_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_multi_rd_q <= 1'b0;
      err_multi_wr_q <= 1'b0;
      err_addr_oob_q <= 1'b0;
    end else begin
      err_multi_rd_q <= err_multi_rd_d;
      err_multi_wr_q <= err_multi_wr_d;
      err_addr_oob_q <= err_addr_oob_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_dst       = rd_dst_q;
  assign err_multi_rd = err_multi_rd_q;
  assign err_multi_wr = err_multi_wr_q;
  assign err_addr_oob = err_addr_oob_q;

endmodule
